// File: rtl/mmio_bus_arbiter_if.sv
// mmio_bus_arbiter_if
// Bundles the two requester ports and the MMIO bus port of the arbiter.
//   Requester side : req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 (to arbiter)
//                    ack0/ack1, gnt0/gnt1, respData              (from arbiter)
//   Bus side       : busAddress, busWriteData, busReadEnable,
//                    busWriteEnable                              (from arbiter)
//                    busReadData                                 (to arbiter)
// Modports:
//   slave  - the arbiter itself.
//   master - the environment around it: both requesters plus the bus target
//            that returns busReadData.
interface mmio_bus_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic        gnt0;
    logic        gnt1;
    logic [31:0] respData;
    logic [31:0] busAddress;
    logic [31:0] busWriteData;
    logic        busReadEnable;
    logic        busWriteEnable;
    logic [31:0] busReadData;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, busReadData,
        output ack0, ack1, gnt0, gnt1, respData,
               busAddress, busWriteData, busReadEnable, busWriteEnable
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, busReadData,
        input  ack0, ack1, gnt0, gnt1, respData,
               busAddress, busWriteData, busReadEnable, busWriteEnable
    );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter
// Two-requester round-robin arbiter and single-transaction sequencer for the
// MMIO bus. Requester 0 is the CPU load/store port, requester 1 a loader or
// debug master. One transaction runs at a time: IDLE picks a winner and
// latches its fields, ACCESS drives the bus, WAIT stretches reads by
// READ_LATENCY cycles, DONE pulses the owner's ack.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mmio_bus_arbiter_if.slave (requester handshakes + bus signals)
// Parameter:
//   READ_LATENCY - cycles busReadEnable is held after ACCESS before the read
//                  data is captured (0..7)
module mmio_bus_arbiter #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    mmio_bus_arbiter_if.slave bus
);

    localparam logic [2:0] LATENCY_LOAD = 3'(READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arbState;

    arbState     stateReg, stateNext;
    logic        ownerReg, ownerNext;
    logic        weReg, weNext;
    logic        rrPtrReg, rrPtrNext;
    logic [31:0] addrReg, addrNext;
    logic [31:0] wdataReg, wdataNext;
    logic [31:0] respReg, respNext;
    logic [2:0]  countReg, countNext;

    logic        winner;
    logic        readEn;
    logic        writeEn;
    logic        ackOut;
    logic        busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= IDLE;
            ownerReg <= 1'b0;
            weReg    <= 1'b0;
            rrPtrReg <= 1'b0;
            addrReg  <= '0;
            wdataReg <= '0;
            respReg  <= '0;
            countReg <= '0;
        end else begin
            stateReg <= stateNext;
            ownerReg <= ownerNext;
            weReg    <= weNext;
            rrPtrReg <= rrPtrNext;
            addrReg  <= addrNext;
            wdataReg <= wdataNext;
            respReg  <= respNext;
            countReg <= countNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        ownerNext = ownerReg;
        weNext    = weReg;
        rrPtrNext = rrPtrReg;
        addrNext  = addrReg;
        wdataNext = wdataReg;
        respNext  = respReg;
        countNext = countReg;
        winner    = 1'b0;
        readEn    = 1'b0;
        writeEn   = 1'b0;
        ackOut    = 1'b0;

        case (stateReg)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Under contention the pointer decides; a lone request
                    // wins outright. The pointer always moves to the loser so
                    // a waiting requester is served next.
                    winner    = (bus.req0 && bus.req1) ? rrPtrReg : bus.req1;
                    ownerNext = winner;
                    weNext    = winner ? bus.we1    : bus.we0;
                    addrNext  = winner ? bus.addr1  : bus.addr0;
                    wdataNext = winner ? bus.wdata1 : bus.wdata0;
                    rrPtrNext = ~winner;
                    stateNext = ACCESS;
                end
            end

            ACCESS: begin
                if (weReg) begin
                    writeEn   = 1'b1;
                    stateNext = DONE;
                end else begin
                    readEn = 1'b1;
                    if (READ_LATENCY == 0) begin
                        respNext  = bus.busReadData;
                        stateNext = DONE;
                    end else begin
                        countNext = LATENCY_LOAD;
                        stateNext = WAIT;
                    end
                end
            end

            WAIT: begin
                readEn    = 1'b1;
                countNext = countReg - 3'd1;
                if (countReg == 3'd1) begin
                    respNext  = bus.busReadData;
                    stateNext = DONE;
                end
            end

            DONE: begin
                ackOut    = 1'b1;
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Everything the requesters and bus see is decoded from registered state,
    // so an asynchronous reset clears all outputs without waiting for a clock.
    assign busy = (stateReg != IDLE);

    assign bus.gnt0           = busy & ~ownerReg;
    assign bus.gnt1           = busy &  ownerReg;
    assign bus.ack0           = ackOut & ~ownerReg;
    assign bus.ack1           = ackOut &  ownerReg;
    assign bus.respData       = respReg;
    assign bus.busAddress     = addrReg;
    assign bus.busWriteData   = wdataReg;
    assign bus.busReadEnable  = readEn;
    assign bus.busWriteEnable = writeEn;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
module tb_mmio_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checkCount = 0;
    int   errorCount = 0;

    always #5 clk = ~clk;

    mmio_bus_arbiter_if busIf ();
    mmio_bus_arbiter_if busIfL0 ();
    mmio_bus_arbiter_if busIfL3 ();

    mmio_bus_arbiter #(.READ_LATENCY(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    mmio_bus_arbiter #(.READ_LATENCY(0)) dutL0 (
        .clk (clk),
        .rst (rst),
        .bus (busIfL0)
    );

    mmio_bus_arbiter #(.READ_LATENCY(3)) dutL3 (
        .clk (clk),
        .rst (rst),
        .bus (busIfL3)
    );

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero();
        checkValue("zero.ack0",    {31'd0, busIf.ack0}, 32'd0);
        checkValue("zero.ack1",    {31'd0, busIf.ack1}, 32'd0);
        checkValue("zero.gnt0",    {31'd0, busIf.gnt0}, 32'd0);
        checkValue("zero.gnt1",    {31'd0, busIf.gnt1}, 32'd0);
        checkValue("zero.resp",    busIf.respData, 32'd0);
        checkValue("zero.addr",    busIf.busAddress, 32'd0);
        checkValue("zero.wdata",   busIf.busWriteData, 32'd0);
        checkValue("zero.readEn",  {31'd0, busIf.busReadEnable}, 32'd0);
        checkValue("zero.writeEn", {31'd0, busIf.busWriteEnable}, 32'd0);
    endtask

    // Runs until n acks are seen (bounded), recording the ack order as bits.
    task automatic collectAcks(input int n, output logic [7:0] order);
        int got;
        got   = 0;
        order = 8'd0;
        for (int c = 0; c < 200 && got < n; c++) begin
            tick();
            checkValue("enExclusive",  {31'd0, busIf.busReadEnable & busIf.busWriteEnable}, 32'd0);
            checkValue("gntExclusive", {31'd0, busIf.gnt0 & busIf.gnt1}, 32'd0);
            checkValue("ackExclusive", {31'd0, busIf.ack0 & busIf.ack1}, 32'd0);
            if (busIf.ack0 || busIf.ack1) begin
                order[got[2:0]] = busIf.ack1;
                $display("txn %0d: ack from requester %0d resp=0x%08h", got, busIf.ack1, busIf.respData);
                got++;
            end
            if (got == n) begin
                busIf.req0 = 1'b0;
                busIf.req1 = 1'b0;
            end
        end
        checkValue("ackCount", got, n);
    endtask

    initial begin
        logic [7:0] order;

        busIf.req0 = 0; busIf.req1 = 0; busIf.we0 = 0; busIf.we1 = 0;
        busIf.addr0 = 0; busIf.addr1 = 0; busIf.wdata0 = 0; busIf.wdata1 = 0;
        busIf.busReadData = 0;
        busIfL0.req0 = 0; busIfL0.req1 = 0; busIfL0.we0 = 0; busIfL0.we1 = 0;
        busIfL0.addr0 = 0; busIfL0.addr1 = 0; busIfL0.wdata0 = 0; busIfL0.wdata1 = 0;
        busIfL0.busReadData = 0;
        busIfL3.req0 = 0; busIfL3.req1 = 0; busIfL3.we0 = 0; busIfL3.we1 = 0;
        busIfL3.addr0 = 0; busIfL3.addr1 = 0; busIfL3.wdata0 = 0; busIfL3.wdata1 = 0;
        busIfL3.busReadData = 0;

        // Reset state
        tick();
        tick();
        checkAllZero();
        rst = 1'b0;

        // Read by requester 0, latency 1
        busIf.req0 = 1; busIf.we0 = 0; busIf.addr0 = 32'h0000_0010;
        busIf.busReadData = 32'hDEAD_BEEF;
        tick();
        checkValue("rd.c1.readEn", {31'd0, busIf.busReadEnable}, 32'd1);
        checkValue("rd.c1.gnt0",   {31'd0, busIf.gnt0}, 32'd1);
        checkValue("rd.c1.gnt1",   {31'd0, busIf.gnt1}, 32'd0);
        checkValue("rd.c1.addr",   busIf.busAddress, 32'h0000_0010);
        checkValue("rd.c1.ack0",   {31'd0, busIf.ack0}, 32'd0);
        tick();
        checkValue("rd.c2.readEn", {31'd0, busIf.busReadEnable}, 32'd1);
        checkValue("rd.c2.gnt1",   {31'd0, busIf.gnt1}, 32'd0);
        checkValue("rd.c2.ack0",   {31'd0, busIf.ack0}, 32'd0);
        tick();
        checkValue("rd.c3.ack0",   {31'd0, busIf.ack0}, 32'd1);
        checkValue("rd.c3.resp",   busIf.respData, 32'hDEAD_BEEF);
        checkValue("rd.c3.readEn", {31'd0, busIf.busReadEnable}, 32'd0);
        checkValue("rd.c3.gnt1",   {31'd0, busIf.gnt1}, 32'd0);
        $display("txn read req0 addr=0x%08h resp=0x%08h", busIf.busAddress, busIf.respData);
        busIf.req0 = 0;
        tick();
        checkValue("rd.c4.ack0", {31'd0, busIf.ack0}, 32'd0);
        checkValue("rd.c4.gnt0", {31'd0, busIf.gnt0}, 32'd0);

        // Write by requester 1
        busIf.req1 = 1; busIf.we1 = 1; busIf.addr1 = 32'h0000_0200; busIf.wdata1 = 32'h0000_1234;
        tick();
        checkValue("wr.c1.writeEn", {31'd0, busIf.busWriteEnable}, 32'd1);
        checkValue("wr.c1.readEn",  {31'd0, busIf.busReadEnable}, 32'd0);
        checkValue("wr.c1.addr",    busIf.busAddress, 32'h0000_0200);
        checkValue("wr.c1.wdata",   busIf.busWriteData, 32'h0000_1234);
        checkValue("wr.c1.gnt1",    {31'd0, busIf.gnt1}, 32'd1);
        tick();
        checkValue("wr.c2.ack1",    {31'd0, busIf.ack1}, 32'd1);
        checkValue("wr.c2.writeEn", {31'd0, busIf.busWriteEnable}, 32'd0);
        checkValue("wr.c2.resp",    busIf.respData, 32'hDEAD_BEEF);
        $display("txn write req1 addr=0x%08h data=0x%08h", busIf.busAddress, busIf.busWriteData);
        busIf.req1 = 0;
        tick();
        checkValue("wr.c3.gnt1", {31'd0, busIf.gnt1}, 32'd0);
        checkValue("wr.c3.addrHold", busIf.busAddress, 32'h0000_0200);

        // Continuous contention: requester 0 reads, requester 1 writes
        busIf.req0 = 1; busIf.we0 = 0; busIf.addr0 = 32'h0000_0020;
        busIf.busReadData = 32'h0BAD_F00D;
        busIf.req1 = 1; busIf.we1 = 1; busIf.addr1 = 32'h0000_0300; busIf.wdata1 = 32'h0000_5678;
        collectAcks(8, order);
        checkValue("rrOrder", {24'd0, order}, 32'h0000_00AA);
        tick();

        // Requester 1 alone, requester 0 arrives during its WAIT
        busIf.req1 = 1; busIf.we1 = 0; busIf.addr1 = 32'h0000_0304;
        busIf.busReadData = 32'h1357_9BDF;
        tick();
        checkValue("late.c1.gnt1", {31'd0, busIf.gnt1}, 32'd1);
        tick();
        checkValue("late.c2.readEn", {31'd0, busIf.busReadEnable}, 32'd1);
        busIf.req0 = 1; busIf.we0 = 0; busIf.addr0 = 32'h0000_0024;
        tick();
        checkValue("late.c3.ack1", {31'd0, busIf.ack1}, 32'd1);
        $display("txn read req1 resp=0x%08h", busIf.respData);
        tick();
        tick();
        checkValue("late.next.gnt0", {31'd0, busIf.gnt0}, 32'd1);
        checkValue("late.next.gnt1", {31'd0, busIf.gnt1}, 32'd0);
        checkValue("late.next.addr", busIf.busAddress, 32'h0000_0024);
        collectAcks(2, order);
        checkValue("lateOrder", {24'd0, order}, 32'h0000_0002);
        tick();

        // Reset during WAIT of a requester 0 read
        busIf.req0 = 1; busIf.we0 = 0; busIf.addr0 = 32'h0000_0040;
        busIf.busReadData = 32'h1111_2222;
        tick();
        tick();
        checkValue("rst.wait.readEn", {31'd0, busIf.busReadEnable}, 32'd1);
        rst = 1'b1;
        #1;
        checkAllZero();
        tick();
        checkValue("rst.hold.ack0", {31'd0, busIf.ack0}, 32'd0);
        checkValue("rst.hold.gnt0", {31'd0, busIf.gnt0}, 32'd0);
        rst = 1'b0;
        tick();
        checkValue("rst.c1.gnt0", {31'd0, busIf.gnt0}, 32'd1);
        checkValue("rst.c1.addr", busIf.busAddress, 32'h0000_0040);
        tick();
        checkValue("rst.c2.ack0", {31'd0, busIf.ack0}, 32'd0);
        tick();
        checkValue("rst.c3.ack0", {31'd0, busIf.ack0}, 32'd1);
        checkValue("rst.c3.resp", busIf.respData, 32'h1111_2222);
        $display("txn read req0 after reset resp=0x%08h", busIf.respData);
        busIf.req0 = 0;
        tick();

        // READ_LATENCY = 0 and 3 builds side by side
        busIfL0.req0 = 1; busIfL0.addr0 = 32'h0000_0080; busIfL0.busReadData = 32'hA5A5_A5A5;
        busIfL3.req0 = 1; busIfL3.addr0 = 32'h0000_0080; busIfL3.busReadData = 32'hA5A5_A5A5;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checkValue($sformatf("lat0.c%0d.ack0", k), {31'd0, busIfL0.ack0}, {31'd0, k == 2});
            checkValue($sformatf("lat0.c%0d.readEn", k), {31'd0, busIfL0.busReadEnable}, {31'd0, k == 1});
            checkValue($sformatf("lat3.c%0d.ack0", k), {31'd0, busIfL3.ack0}, {31'd0, k == 5});
            checkValue($sformatf("lat3.c%0d.readEn", k), {31'd0, busIfL3.busReadEnable},
                       {31'd0, (k >= 1) && (k <= 4)});
            if (k == 2) begin
                checkValue("lat0.resp", busIfL0.respData, 32'hA5A5_A5A5);
                $display("txn read latency0 resp=0x%08h", busIfL0.respData);
                busIfL0.req0 = 0;
            end
            if (k == 5) begin
                checkValue("lat3.resp", busIfL3.respData, 32'hA5A5_A5A5);
                $display("txn read latency3 resp=0x%08h", busIfL3.respData);
                busIfL3.req0 = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
